vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters:
  - the VGA display fetch, driven by the sync generator's vga_video_on / vga_h_addr / vga_v_addr;
  - a pixel writer (CPU or draw engine) using a valid/ready handshake.
- The display has absolute priority. Writes are held in a one-entry buffer and drain on any cycle without a display read, in practice during h/v blanking.
- Sits between vga_sync, the frame-buffer RAM, and the DAC output register stage.

Parameters:
- HRES, 640, visible pixels per line
- VRES, 480, visible lines per frame
- HADDRW, 10, width of vga_h_addr
- VADDRW, 9, width of vga_v_addr
- AW, 19, RAM address width; must satisfy 2**AW >= HRES*VRES
- DW, 8, pixel width

Ports:
- vga_clk  input  1  single clock for the whole block
- rst  input  1  synchronous, active-high reset
- vga_video_on  input  1  display read request for this cycle
- vga_h_addr  input  HADDRW  display column
- vga_v_addr  input  VADDRW  display row
- wr_valid  input  1  writer request
- wr_ready  output  1  writer may transfer
- wr_addr  input  AW  linear pixel address
- wr_data  input  DW  pixel value
- mem_addr  output  AW  RAM address (registered)
- mem_we  output  1  RAM write enable (registered)
- mem_wdata  output  DW  RAM write data (registered)
- mem_rdata  input  DW  RAM read data, valid 1 cycle after mem_addr
- pix_data  output  DW  pixel to DAC (registered)
- pix_valid  output  1  pix_data corresponds to a display read

Behaviour:
- Clock/reset: one clock (vga_clk); reset (rst) is synchronous and active-high.
- Reset values: mem_addr=0, mem_we=0, mem_wdata=0, pix_data=0, pix_valid=0. Internally: buf_valid=0, state=IDLE, read tag pipeline cleared.
- Slot state machine, one-hot {IDLE, DISP, WRITE}, re-evaluated every cycle:
  - vga_video_on=1 -> DISP
  - else buf_valid=1 -> WRITE
  - else -> IDLE
  - No hysteresis; any state can reach any state in one cycle.
- DISP:
  - Next cycle: mem_addr = vga_v_addr*HRES + vga_h_addr (AW bits, computed unsigned), mem_we=0.
  - A display tag is set in the read pipeline.
- WRITE:
  - Next cycle: mem_addr=buf_addr, mem_wdata=buf_data, mem_we=1.
  - buf_valid cleared.
- IDLE: mem_we=0; mem_addr holds its previous value.
- Display latency: vga_video_on sampled at cycle t -> mem_addr at t+1 -> mem_rdata at t+2 -> pix_data/pix_valid registered at t+3. Fixed 3 cycles, including back-to-back across line boundaries.
- When the tag at t+2 is not a display read: pix_data=0, pix_valid=0 (blank level).
- Write handshake:
  - wr_ready = !buf_valid || !vga_video_on. Combinational from vga_video_on and buf_valid only; never depends on wr_valid.
  - Transfer on wr_valid && wr_ready: captures wr_addr/wr_data into the buffer, buf_valid=1.
  - Transfer in the same cycle the buffer drains (WRITE slot): the old entry goes to RAM and the new entry is loaded. Throughput is 1 write per blanking cycle.
  - Writer must hold wr_valid/wr_addr/wr_data stable until the transfer.
- Out-of-range write (wr_addr >= HRES*VRES): handshake completes, entry discarded at drain, mem_we stays 0 for that slot.
- Write during active video with the buffer full: wr_ready=0 until the first cycle with vga_video_on=0.
- Address arithmetic: product width HADDRW+VADDRW+1 internally, truncated to AW. Inputs beyond HRES/VRES are not checked.
- rst asserted mid-operation: pending buffered write is lost; in-flight display reads are dropped, so pix_valid=0 from the cycle after rst.

Optional Feature:
- Macro: VGA_FB_ARB_STAT_EN.
- Defined, adds outputs:
  - stat_wr_stall[15:0]: saturating count of cycles with wr_valid=1 and wr_ready=0.
  - stat_wr_drop[15:0]: saturating count of out-of-range writes discarded.
  - stat_clr (input): synchronous clear of both counters; priority over increment in the same cycle.
  - Both counters reset to 0.
- Not defined: no ports, no counter logic; all other behaviour identical.

Test Plan:
- Reset, then idle (video_on=0, wr_valid=0) for 10 cycles -> mem_we=0, pix_valid=0, pix_data=0, wr_ready=1.
- video_on=1 with h=5, v=2 at cycle t -> mem_addr=1285 at t+1; RAM preloaded 0xA5 there -> pix_data=0xA5, pix_valid=1 at t+3.
- Blanking, wr_valid=1 with addr=100, data=0x3C for 4 consecutive transfers (addr 100..103) -> one mem_we pulse per cycle, addresses 100..103 in order, wr_ready stays 1.
- video_on=1 for 640 cycles with a write pending and wr_valid held -> wr_ready=0 throughout, mem_we=0 throughout; write lands on the 1st cycle after video_on falls.
- wr_addr=307200 in blanking -> transfer completes, no mem_we; with VGA_FB_ARB_STAT_EN, stat_wr_drop=1.
- rst pulsed 1 cycle while buffer full and 2 display reads in flight -> no mem_we afterwards, pix_valid=0 next 3 cycles, wr_ready=1.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle between vga_sync / pixel writer / frame-buffer RAM / DAC stage and
// vga_fb_arbiter. The slave modport is the arbiter's view; master is the environment's.
interface vga_fb_arbiter_if #(
    parameter int unsigned HADDRW = 10,
    parameter int unsigned VADDRW = 9,
    parameter int unsigned AW     = 19,
    parameter int unsigned DW     = 8
) ();
    // Display fetch request from the sync generator
    logic              vga_video_on;
    logic [HADDRW-1:0] vga_h_addr;
    logic [VADDRW-1:0] vga_v_addr;

    // Pixel writer handshake
    logic              wr_valid;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;

    // Frame-buffer RAM port
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    // DAC output stage
    logic [DW-1:0]     pix_data;
    logic              pix_valid;

    modport master (
        output vga_video_on, vga_h_addr, vga_v_addr,
        output wr_valid, wr_addr, wr_data,
        output mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata, pix_data, pix_valid
    );

    modport slave (
        input  vga_video_on, vga_h_addr, vga_v_addr,
        input  wr_valid, wr_addr, wr_data,
        input  mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata, pix_data, pix_valid
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display fetch has absolute priority, writer drains through a
// one-entry buffer in non-display cycles. Define VGA_FB_ARB_STAT_EN to add stall/drop counters.
module vga_fb_arbiter #(
    parameter int unsigned HRES   = 640,
    parameter int unsigned VRES   = 480,
    parameter int unsigned HADDRW = 10,
    parameter int unsigned VADDRW = 9,
    parameter int unsigned AW     = 19,
    parameter int unsigned DW     = 8
) (
    input  logic                   vga_clk,
    input  logic                   rst,
`ifdef VGA_FB_ARB_STAT_EN
    input  logic                   stat_clr,
    output logic [15:0]            stat_wr_stall,
    output logic [15:0]            stat_wr_drop,
`endif
    vga_fb_arbiter_if.slave        bus
);

    localparam int unsigned PW   = HADDRW + VADDRW + 1;
    localparam logic [AW:0] NPIX = (AW+1)'(HRES * VRES);

    // One-hot slot owner for the RAM in the next cycle
    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StDisp  = 3'b010,
        StWrite = 3'b100
    } slot_e;

    slot_e          state_q, state_d;

    logic           buf_valid_q, buf_valid_d;
    logic [AW-1:0]  buf_addr_q, buf_addr_d;
    logic [DW-1:0]  buf_data_q, buf_data_d;

    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic           mem_we_q, mem_we_d;
    logic [DW-1:0]  mem_wdata_q, mem_wdata_d;

    logic           disp_tag_q;
    logic [DW-1:0]  pix_data_q, pix_data_d;
    logic           pix_valid_q, pix_valid_d;

    logic [PW-1:0]  disp_lin;
    logic           buf_in_range;
    logic           wr_ready;
    logic           wr_xfer;

    assign disp_lin     = PW'(bus.vga_v_addr) * PW'(HRES) + PW'(bus.vga_h_addr);
    assign buf_in_range = ({1'b0, buf_addr_q} < NPIX);

    // Ready only looks at the buffer and the display request, never at wr_valid
    assign wr_ready = !buf_valid_q || !bus.vga_video_on;
    assign wr_xfer  = bus.wr_valid && wr_ready;

    always_comb begin
        state_d     = StIdle;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        if (bus.vga_video_on) begin
            state_d = StDisp;
        end else if (buf_valid_q) begin
            state_d = StWrite;
        end

        unique case (state_d)
            StDisp: begin
                mem_addr_d = AW'(disp_lin);
            end
            StWrite: begin
                buf_valid_d = 1'b0;
                // Out-of-range entries are silently discarded; the slot stays a no-op
                if (buf_in_range) begin
                    mem_addr_d  = buf_addr_q;
                    mem_wdata_d = buf_data_q;
                    mem_we_d    = 1'b1;
                end
            end
            default: ;
        endcase

        // A new entry may load in the same cycle the old one drains
        if (wr_xfer) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = bus.wr_addr;
            buf_data_d  = bus.wr_data;
        end

        pix_valid_d = disp_tag_q;
        pix_data_d  = disp_tag_q ? bus.mem_rdata : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            disp_tag_q  <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            // state_q == StDisp marks the cycle mem_addr carries a display read
            disp_tag_q  <= (state_q == StDisp);
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_valid = pix_valid_q;

`ifdef VGA_FB_ARB_STAT_EN
    logic [15:0] stall_q, drop_q;
    logic        stall_evt, drop_evt;

    assign stall_evt = bus.wr_valid && !wr_ready;
    assign drop_evt  = (state_d == StWrite) && !buf_in_range;

    always_ff @(posedge vga_clk) begin
        if (rst || stat_clr) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if (stall_evt && (stall_q != 16'hffff)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (drop_evt && (drop_q != 16'hffff)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign stat_wr_stall = stall_q;
    assign stat_wr_drop  = drop_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model of the RAM slot rules and a shadow frame buffer.
module tb_vga_fb_arbiter;

    localparam int unsigned HRES   = 640;
    localparam int unsigned VRES   = 480;
    localparam int unsigned HADDRW = 10;
    localparam int unsigned VADDRW = 9;
    localparam int unsigned AW     = 19;
    localparam int unsigned DW     = 8;
    localparam int unsigned NPIX   = HRES * VRES;
    localparam int unsigned MSIZE  = 1 << AW;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;

    vga_fb_arbiter_if #(.HADDRW(HADDRW), .VADDRW(VADDRW), .AW(AW), .DW(DW)) bus ();

`ifdef VGA_FB_ARB_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_wr_stall;
    logic [15:0] stat_wr_drop;
`endif

    vga_fb_arbiter #(
        .HRES(HRES), .VRES(VRES), .HADDRW(HADDRW), .VADDRW(VADDRW), .AW(AW), .DW(DW)
    ) dut (
        .vga_clk       (vga_clk),
        .rst           (rst),
`ifdef VGA_FB_ARB_STAT_EN
        .stat_clr      (stat_clr),
        .stat_wr_stall (stat_wr_stall),
        .stat_wr_drop  (stat_wr_drop),
`endif
        .bus           (bus)
    );

    initial forever #5 vga_clk = ~vga_clk;

    // Synchronous single-port RAM, read data one cycle after address
    logic [DW-1:0] ram    [MSIZE];
    logic [DW-1:0] shadow [MSIZE];

    always @(posedge vga_clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
    } pix_t;

    int unsigned   n_total = 0;
    int unsigned   n_bad   = 0;

    bit            m_buf_v;
    int unsigned   m_buf_a;
    logic [DW-1:0] m_buf_d;
    int unsigned   m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_we;
    int unsigned   m_stall;
    int unsigned   m_drop;
    pix_t          pq[$];
    bit            last_xfer;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_buf_v = 1'b0;
        m_addr  = 0;
        m_wdata = '0;
        m_we    = 1'b0;
        m_stall = 0;
        m_drop  = 0;
        pq.delete();
        repeat (3) pq.push_back('{1'b0, '0});
    endtask

    // One clock: check outputs against the model, then advance the model with current inputs
    task automatic tick();
        pix_t e;
        bit   ready;
        bit   xfer;
        @(negedge vga_clk);
        check_eq("mem_we", 32'(bus.mem_we), 32'(m_we));
        check_eq("mem_addr", 32'(bus.mem_addr), m_addr);
        check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
        e = pq.pop_front();
        check_eq("pix_valid", 32'(bus.pix_valid), 32'(e.v));
        check_eq("pix_data", 32'(bus.pix_data), 32'(e.d));
`ifdef VGA_FB_ARB_STAT_EN
        check_eq("stat_wr_stall", 32'(stat_wr_stall), m_stall);
        check_eq("stat_wr_drop", 32'(stat_wr_drop), m_drop);
`endif
        last_xfer = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            ready = !m_buf_v || !bus.vga_video_on;
            check_eq("wr_ready", 32'(bus.wr_ready), 32'(ready));
            xfer = bus.wr_valid && ready;
            if (bus.wr_valid && !ready && m_stall < 65535) m_stall++;
            if (bus.vga_video_on) begin
                m_we   = 1'b0;
                m_addr = (int'(bus.vga_v_addr) * HRES + int'(bus.vga_h_addr)) % MSIZE;
                pq.push_back('{1'b1, shadow[m_addr]});
            end else if (m_buf_v) begin
                m_buf_v = 1'b0;
                pq.push_back('{1'b0, '0});
                if (m_buf_a < NPIX) begin
                    m_we            = 1'b1;
                    m_addr          = m_buf_a;
                    m_wdata         = m_buf_d;
                    shadow[m_buf_a] = m_buf_d;
                end else begin
                    m_we = 1'b0;
                    if (m_drop < 65535) m_drop++;
                end
            end else begin
                m_we = 1'b0;
                pq.push_back('{1'b0, '0});
            end
            if (xfer) begin
                m_buf_v   = 1'b1;
                m_buf_a   = int'(bus.wr_addr);
                m_buf_d   = bus.wr_data;
                last_xfer = 1'b1;
            end
`ifdef VGA_FB_ARB_STAT_EN
            if (stat_clr) begin
                m_stall = 0;
                m_drop  = 0;
            end
`endif
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drive(input bit von, input int unsigned h, input int unsigned v,
                         input bit wv, input int unsigned wa, input int unsigned wd);
        bus.vga_video_on = von;
        bus.vga_h_addr   = HADDRW'(h);
        bus.vga_v_addr   = VADDRW'(v);
        bus.wr_valid     = wv;
        bus.wr_addr      = AW'(wa);
        bus.wr_data      = DW'(wd);
    endtask

    int unsigned burst_left;
    bit          burst_on;
    int unsigned hcnt;
    int unsigned wa;

    initial begin
        for (int i = 0; i < int'(MSIZE); i++) begin
            ram[i]    = DW'(i ^ (i >> 9));
            shadow[i] = DW'(i ^ (i >> 9));
        end
        ram[1285]    = 8'hA5;
        shadow[1285] = 8'hA5;

        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge vga_clk);
        #1;
        model_reset();
        tick();
        rst = 1'b0;

        // Idle after reset
        repeat (10) tick();

        // Single display read of a preloaded pixel
        drive(1, 5, 2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Back-to-back writes during blanking
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 100 + k, 8'h3C);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Buffer fills during active video, second writer stalls for a full line
        drive(1, 0, 10, 1, 200, 8'h11);
        tick();
        for (int i = 0; i < 640; i++) begin
            drive(1, i, 10, 1, 201, 8'h22);
            tick();
        end
        drive(0, 0, 0, 1, 201, 8'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Read back the written pixels
        drive(1, 200, 0, 0, 0, 0);
        tick();
        drive(1, 201, 0, 0, 0, 0);
        tick();
        drive(1, 100, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Out-of-range writes at and just below the frame boundary
        drive(0, 0, 0, 1, NPIX, 8'h77);
        tick();
        drive(0, 0, 0, 1, NPIX - 1, 8'h78);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset with a full buffer and display reads in flight
        drive(1, 3, 0, 1, 300, 8'h99);
        tick();
        drive(1, 4, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Randomized traffic
        burst_left = 0;
        burst_on   = 1'b0;
        hcnt       = 0;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            if (burst_left == 0) begin
                burst_on   = ($urandom_range(0, 1) == 1);
                burst_left = burst_on ? $urandom_range(1, 40) : $urandom_range(1, 12);
                hcnt       = $urandom_range(0, 600);
            end
            burst_left--;
            bus.vga_video_on = burst_on;
            bus.vga_h_addr   = HADDRW'(hcnt);
            bus.vga_v_addr   = VADDRW'($urandom_range(0, 3));
            hcnt++;
            if (!bus.wr_valid || last_xfer) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 15))
                        0:       wa = NPIX;
                        1:       wa = NPIX - 1;
                        2:       wa = $urandom_range(NPIX, MSIZE - 1);
                        default: wa = $urandom_range(0, 4 * HRES - 1);
                    endcase
                    bus.wr_valid = 1'b1;
                    bus.wr_addr  = AW'(wa);
                    bus.wr_data  = DW'($urandom);
                end else begin
                    bus.wr_valid = 1'b0;
                end
            end
`ifdef VGA_FB_ARB_STAT_EN
            stat_clr = ($urandom_range(0, 99) == 0);
`endif
            if ($urandom_range(0, 399) == 0) begin
                rst          = 1'b1;
                bus.wr_valid = 1'b0;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
`ifdef VGA_FB_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
